// File: rtl/hpdcache_l15_responder_pkg.sv
// hpdcache_l15_responder_pkg: L1.5 request/return types, responder FSM states and FIFO entry.
package hpdcache_l15_responder_pkg;
   localparam int HPDCACHE_PA_WIDTH = 40;
   localparam int L15_TID_WIDTH = 2;
   typedef enum logic [4:0] {
      L15_LOAD_RQ  = 5'b00000,
      L15_STORE_RQ = 5'b00001,
      L15_IMISS_RQ = 5'b10000
   } l15_reqtypes_t;
   typedef enum logic [3:0] {
      L15_LOAD_RET  = 4'b0000,
      L15_IFILL_RET = 4'b0001,
      L15_EVICT_REQ = 4'b0011,
      L15_ST_ACK    = 4'b0100,
      L15_ERR_RET   = 4'b1100
   } l15_rtrntypes_t;
   typedef struct packed {
      logic                         l15_val;
      logic                         l15_req_ack;
      l15_reqtypes_t                l15_rqtype;
      logic                         l15_nc;
      logic [2:0]                   l15_size;
      logic [L15_TID_WIDTH-1:0]     l15_threadid;
      logic [HPDCACHE_PA_WIDTH-1:0] l15_address;
      logic [63:0]                  l15_data;
   } l15_req_t;
   typedef struct packed {
      logic                     l15_ack;
      logic                     l15_val;
      l15_rtrntypes_t           l15_returntype;
      logic                     l15_error;
      logic                     l15_noncacheable;
      logic [L15_TID_WIDTH-1:0] l15_threadid;
      logic [63:0]              l15_data_0;
      logic [63:0]              l15_data_1;
      logic [63:0]              l15_data_2;
      logic [63:0]              l15_data_3;
      logic                     l15_inval_icache_inval;
      logic                     l15_inval_dcache_inval;
      logic [11:0]              l15_inval_address_15_4;
   } l15_rtrn_t;
   typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, RTRN, INVAL} hpdc_l15_resp_state_t;
   typedef struct packed {
      l15_reqtypes_t                rqtype;
      logic                         nc;
      logic [2:0]                   size;
      logic [L15_TID_WIDTH-1:0]     threadid;
      logic [HPDCACHE_PA_WIDTH-1:0] address;
      logic [63:0]                  data;
   } hpdc_l15_fifo_ent_t;
   function automatic logic [63:0] swap64(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
      return r;
   endfunction
endpackage

// File: rtl/hpdcache_l15_responder_if.sv
// hpdcache_l15_responder_if: L1.5 request/return channel plus the fixed-width memory port.
// slave is the responder's view, master the requester/memory side.
interface hpdcache_l15_responder_if
   import hpdcache_l15_responder_pkg::*;
#(
   parameter int MemDataWidth = 256,
   parameter int MemAddrWidth = HPDCACHE_PA_WIDTH
) ();
   l15_req_t                  l15_req;
   l15_rtrn_t                 l15_rtrn;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic                      mem_req_we;
   logic [MemAddrWidth-1:0]   mem_req_addr;
   logic [MemDataWidth/8-1:0] mem_req_be;
   logic [MemDataWidth-1:0]   mem_req_wdata;
   logic                      mem_rsp_valid;
   logic [MemDataWidth-1:0]   mem_rsp_rdata;
   logic                      inval_valid;
   logic [MemAddrWidth-1:0]   inval_addr;
   modport slave (
      input  l15_req, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, inval_valid, inval_addr,
      output l15_rtrn, mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata
   );
   modport master (
      output l15_req, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, inval_valid, inval_addr,
      input  l15_rtrn, mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata
   );
endinterface

// File: rtl/hpdcache_l15_responder_store_be.sv
// hpdcache_l15_responder_store_be: store size/address to 32B-line byte enables and error flag.
// Byte index within the line is addr[4:0]; sizes above 8B and misaligned addresses are errors.
module hpdcache_l15_responder_store_be (
   input  logic [2:0]  size_i,
   input  logic [4:0]  addr_i,
   output logic [31:0] be_o,
   output logic        err_o
);
   logic [7:0] mask;
   logic [2:0] align;
   assign mask  = size_i == 3'd0 ? 8'h01 : size_i == 3'd1 ? 8'h03 : size_i == 3'd2 ? 8'h0F : 8'hFF;
   assign align = {&size_i[1:0], size_i[1], |size_i[1:0]};
   assign be_o  = 32'(mask) << addr_i;
   assign err_o = size_i[2] | |(addr_i[2:0] & align);
endmodule

// File: rtl/hpdcache_l15_responder.sv
// hpdcache_l15_responder: L1.5 stand-in serving l15 requests from a 32B memory port via a 2-entry FIFO.
// Define HPDC_L15_RESP_INVAL_EN to forward external invalidations as EVICT_REQ returns.
module hpdcache_l15_responder
   import hpdcache_l15_responder_pkg::*;
#(
   parameter int MemDataWidth  = 256,
   parameter bit SwapEndianess = 1'b1,
   parameter int MemAddrWidth  = HPDCACHE_PA_WIDTH
) (
   input logic clk_i,
   input logic rst_i,
   hpdcache_l15_responder_if.slave bus
);
   hpdc_l15_resp_state_t state_q, state_d;
   hpdc_l15_fifo_ent_t   fifo_q [2];
   hpdc_l15_fifo_ent_t   head;
   logic                      rd_q, wr_q;
   logic [1:0]                cnt_q;
   logic [MemDataWidth-1:0]   line_q;
   logic [MemDataWidth/8-1:0] head_be;
   logic [63:0]               lane [4];
   logic                      full, empty, push, pop, be_err, head_err, mem_valid;
   logic                      is_imiss, is_load, tid_hit, inval_pend;
   logic [11:0]               inval_a;
   l15_rtrn_t                 rtrn;
   assign full  = cnt_q == 2'd2;
   assign empty = cnt_q == 2'd0;
   assign push  = bus.l15_req.l15_val & !full;
   assign pop   = state_q == RTRN & bus.l15_req.l15_req_ack;
   assign head  = fifo_q[rd_q];
   assign tid_hit = cnt_q == 2'd1 && head.threadid == bus.l15_req.l15_threadid;
   hpdcache_l15_responder_store_be u_be (
      .size_i (head.size),
      .addr_i (head.address[4:0]),
      .be_o   (head_be),
      .err_o  (be_err)
   );
   assign head_err = head.rqtype == L15_STORE_RQ & be_err;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         cnt_q   <= 2'd0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         if (push) begin
            fifo_q[wr_q] <= '{bus.l15_req.l15_rqtype, bus.l15_req.l15_nc, bus.l15_req.l15_size,
                              bus.l15_req.l15_threadid, bus.l15_req.l15_address, bus.l15_req.l15_data};
            wr_q <= !wr_q;
         end
         if (pop) rd_q <= !rd_q;
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
         if (state_q == MEM_WAIT && bus.mem_rsp_valid) line_q <= bus.mem_rsp_rdata;
      end
   end
`ifdef HPDC_L15_RESP_INVAL_EN
   logic inval_pend_q;
   logic [11:0] inval_addr_q;
   logic unused_inval_bits;
   assign unused_inval_bits = ^{bus.inval_addr[MemAddrWidth-1:16], bus.inval_addr[3:0]};
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inval_pend_q <= 1'b0;
         inval_addr_q <= '0;
      end else if (bus.inval_valid && !inval_pend_q) begin
         inval_pend_q <= 1'b1;
         inval_addr_q <= bus.inval_addr[15:4];
      end else if (state_q == INVAL && bus.l15_req.l15_req_ack) begin
         inval_pend_q <= 1'b0;
      end
   end
   assign inval_pend = inval_pend_q;
   assign inval_a    = inval_addr_q;
`else
   logic unused_inval;
   assign unused_inval = ^{bus.inval_valid, bus.inval_addr};
   assign inval_pend   = 1'b0;
   assign inval_a      = '0;
`endif
   always_comb begin
      for (int k = 0; k < 4; k++) lane[k] = SwapEndianess ? swap64(line_q[64*k +: 64]) : line_q[64*k +: 64];
   end
   assign is_imiss = head.rqtype == L15_IMISS_RQ;
   assign is_load  = head.rqtype != L15_IMISS_RQ & head.rqtype != L15_STORE_RQ;
   // A new head may be an illegal store: it then skips memory and returns an error.
   always_comb begin
      state_d      = state_q;
      mem_valid    = 1'b0;
      rtrn         = '0;
      rtrn.l15_ack = !full & !rst_i;
      case (state_q)
         IDLE: begin
            if (inval_pend) state_d = INVAL;
            else if (!empty) begin
               mem_valid = !head_err;
               state_d   = head_err ? RTRN : bus.mem_req_ready ? MEM_WAIT : MEM_REQ;
            end
         end
         MEM_REQ: begin
            mem_valid = !head_err;
            state_d   = head_err ? RTRN : bus.mem_req_ready ? MEM_WAIT : MEM_REQ;
         end
         MEM_WAIT: state_d = bus.mem_rsp_valid ? RTRN : MEM_WAIT;
         RTRN: begin
            rtrn.l15_val          = 1'b1;
            rtrn.l15_error        = head_err;
            rtrn.l15_noncacheable = head.nc;
            rtrn.l15_threadid     = head.threadid;
            rtrn.l15_returntype   = head_err ? L15_ERR_RET : is_imiss ? L15_IFILL_RET :
                                    is_load ? L15_LOAD_RET : L15_ST_ACK;
            rtrn.l15_data_0 = is_imiss ? lane[0] : is_load ? (head.address[4] ? lane[2] : lane[0]) : '0;
            rtrn.l15_data_1 = is_imiss ? lane[1] : is_load ? (head.address[4] ? lane[3] : lane[1]) : '0;
            rtrn.l15_data_2 = is_imiss ? lane[2] : '0;
            rtrn.l15_data_3 = is_imiss ? lane[3] : '0;
            if (bus.l15_req.l15_req_ack) state_d = full ? MEM_REQ : IDLE;
         end
         INVAL: begin
            rtrn.l15_val                = 1'b1;
            rtrn.l15_returntype         = L15_EVICT_REQ;
            rtrn.l15_inval_icache_inval = 1'b1;
            rtrn.l15_inval_address_15_4 = inval_a;
            if (bus.l15_req.l15_req_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus.l15_rtrn      = rtrn;
   assign bus.mem_req_valid = mem_valid;
   assign bus.mem_req_we    = head.rqtype == L15_STORE_RQ;
   assign bus.mem_req_addr  = {head.address[MemAddrWidth-1:5], 5'b0};
   assign bus.mem_req_be    = bus.mem_req_we ? head_be : '0;
   assign bus.mem_req_wdata = {(MemDataWidth/64){SwapEndianess ? swap64(head.data) : head.data}};
   // Threads must not have two requests in flight at once.
   assert property (@(posedge clk_i) disable iff (rst_i) !(push && tid_hit));
endmodule

// File: tb/tb_hpdcache_l15_responder.sv
// tb_hpdcache_l15_responder: directed self-checking bench for hpdcache_l15_responder.
module tb_hpdcache_l15_responder;
   import hpdcache_l15_responder_pkg::*;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int errs = 0;
   int checks = 0;
   logic [255:0] line, line_b;
   hpdcache_l15_responder_if bus ();
   hpdcache_l15_responder dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
   always #5 clk_i = !clk_i;

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic send(input l15_reqtypes_t rq, input logic [1:0] tid, input logic [39:0] addr,
                       input logic [2:0] size, input logic [63:0] data);
      bus.l15_req.l15_val      = 1'b1;
      bus.l15_req.l15_rqtype   = rq;
      bus.l15_req.l15_threadid = tid;
      bus.l15_req.l15_address  = addr;
      bus.l15_req.l15_size     = size;
      bus.l15_req.l15_data     = data;
      step();
      bus.l15_req.l15_val = 1'b0;
   endtask

   task automatic do_mem(input logic [255:0] ln, output bit ok, output int waited, output logic [39:0] addr,
                         output logic we, output logic [31:0] be, output logic [255:0] wd);
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < 16 && !ok; i++) begin
         if (bus.mem_req_valid) ok = 1'b1;
         else begin
            waited++;
            step();
         end
      end
      addr = bus.mem_req_addr;
      we   = bus.mem_req_we;
      be   = bus.mem_req_be;
      wd   = bus.mem_req_wdata;
      if (ok) begin
         bus.mem_req_ready = 1'b1;
         step();
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_rdata = ln;
         step();
         bus.mem_rsp_valid = 1'b0;
      end
   endtask

   task automatic wait_rtrn(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         if (bus.l15_rtrn.l15_val) ok = 1'b1;
         else step();
      end
   endtask

   task automatic ack_rtrn();
      bus.l15_req.l15_req_ack = 1'b1;
      step();
      bus.l15_req.l15_req_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) step();
      checks++;
      if (bus.l15_rtrn !== '0) begin errs++; $display("FAIL reset_rtrn: got %h want 0", bus.l15_rtrn); end
      checks++;
      if (bus.mem_req_valid !== 1'b0) begin errs++; $display("FAIL reset_memvalid: got %b want 0", bus.mem_req_valid); end
      rst_i = 1'b0;
      step();
      checks++;
      if (bus.l15_rtrn.l15_ack !== 1'b1) begin errs++; $display("FAIL reset_ack: got %b want 1", bus.l15_rtrn.l15_ack); end
   endtask

   task automatic test_imiss();
      bit ok; int w; logic [39:0] a; logic we; logic [31:0] be; logic [255:0] wd;
      checks++;
      if (bus.l15_rtrn.l15_ack !== 1'b1) begin errs++; $display("FAIL imiss_ack: got %b want 1", bus.l15_rtrn.l15_ack); end
      send(L15_IMISS_RQ, 2'd1, 40'h1000, 3'd0, 64'h0);
      do_mem(line, ok, w, a, we, be, wd);
      checks++;
      if (!ok || w != 0) begin errs++; $display("FAIL imiss_latency: ok=%b waited=%0d want ok=1 waited=0", ok, w); end
      checks++;
      if (a !== 40'h1000 || we !== 1'b0) begin errs++; $display("FAIL imiss_memreq: addr=%h we=%b want 1000/0", a, we); end
      checks++;
      if (bus.l15_rtrn.l15_val !== 1'b1 || bus.l15_rtrn.l15_returntype !== L15_IFILL_RET || bus.l15_rtrn.l15_threadid !== 2'd1)
         begin errs++; $display("FAIL imiss_rtrn: val=%b type=%h tid=%0d want 1/1/1", bus.l15_rtrn.l15_val, bus.l15_rtrn.l15_returntype, bus.l15_rtrn.l15_threadid); end
      checks++;
      if (bus.l15_rtrn.l15_data_0 !== 64'h0001020304050607) begin errs++; $display("FAIL imiss_d0: got %h want 0001020304050607", bus.l15_rtrn.l15_data_0); end
      checks++;
      if (bus.l15_rtrn.l15_data_3 !== 64'h18191a1b1c1d1e1f) begin errs++; $display("FAIL imiss_d3: got %h want 18191a1b1c1d1e1f", bus.l15_rtrn.l15_data_3); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (bus.l15_rtrn.l15_val !== 1'b1 || bus.l15_rtrn.l15_data_0 !== 64'h0001020304050607)
            begin errs++; $display("FAIL imiss_hold%0d: val=%b d0=%h", i, bus.l15_rtrn.l15_val, bus.l15_rtrn.l15_data_0); end
      end
      ack_rtrn();
      checks++;
      if (bus.l15_rtrn.l15_val !== 1'b0) begin errs++; $display("FAIL imiss_pop: val=%b want 0", bus.l15_rtrn.l15_val); end
   endtask

   task automatic test_load();
      bit ok; int w; logic [39:0] a; logic we; logic [31:0] be; logic [255:0] wd;
      send(L15_LOAD_RQ, 2'd2, 40'h2010, 3'b111, 64'h0);
      do_mem(line, ok, w, a, we, be, wd);
      checks++;
      if (!ok || a !== 40'h2000 || we !== 1'b0) begin errs++; $display("FAIL load_memreq: ok=%b addr=%h we=%b want 1/2000/0", ok, a, we); end
      checks++;
      if (bus.l15_rtrn.l15_returntype !== L15_LOAD_RET || bus.l15_rtrn.l15_threadid !== 2'd2)
         begin errs++; $display("FAIL load_type: type=%h tid=%0d want 0/2", bus.l15_rtrn.l15_returntype, bus.l15_rtrn.l15_threadid); end
      checks++;
      if (bus.l15_rtrn.l15_data_0 !== 64'h1011121314151617 || bus.l15_rtrn.l15_data_1 !== 64'h18191a1b1c1d1e1f)
         begin errs++; $display("FAIL load_d01: d0=%h d1=%h want 1011121314151617/18191a1b1c1d1e1f", bus.l15_rtrn.l15_data_0, bus.l15_rtrn.l15_data_1); end
      checks++;
      if (bus.l15_rtrn.l15_data_2 !== 64'h0 || bus.l15_rtrn.l15_data_3 !== 64'h0)
         begin errs++; $display("FAIL load_d23: d2=%h d3=%h want 0/0", bus.l15_rtrn.l15_data_2, bus.l15_rtrn.l15_data_3); end
      ack_rtrn();
   endtask

   task automatic test_store();
      bit ok; int w; logic [39:0] a; logic we; logic [31:0] be; logic [255:0] wd;
      send(L15_STORE_RQ, 2'd3, 40'h3006, 3'd1, 64'hAABB << 48);
      do_mem(line, ok, w, a, we, be, wd);
      checks++;
      if (!ok || a !== 40'h3000 || we !== 1'b1 || be !== 32'h0000_00C0)
         begin errs++; $display("FAIL st2_memreq: ok=%b addr=%h we=%b be=%h want 1/3000/1/000000c0", ok, a, we, be); end
      checks++;
      if (wd !== {4{64'h000000000000BBAA}}) begin errs++; $display("FAIL st2_wdata: got %h", wd); end
      checks++;
      if (bus.l15_rtrn.l15_returntype !== L15_ST_ACK || bus.l15_rtrn.l15_error !== 1'b0 || bus.l15_rtrn.l15_data_0 !== 64'h0)
         begin errs++; $display("FAIL st2_rtrn: type=%h err=%b d0=%h want 4/0/0", bus.l15_rtrn.l15_returntype, bus.l15_rtrn.l15_error, bus.l15_rtrn.l15_data_0); end
      ack_rtrn();
      send(L15_STORE_RQ, 2'd0, 40'h4018, 3'd3, 64'h1122334455667788);
      do_mem(line, ok, w, a, we, be, wd);
      checks++;
      if (!ok || a !== 40'h4000 || be !== 32'hFF00_0000) begin errs++; $display("FAIL st8_be: ok=%b addr=%h be=%h want 1/4000/ff000000", ok, a, be); end
      checks++;
      if (bus.l15_rtrn.l15_returntype !== L15_ST_ACK) begin errs++; $display("FAIL st8_type: got %h want 4", bus.l15_rtrn.l15_returntype); end
      ack_rtrn();
   endtask

   task automatic test_store_err();
      bit seen;
      logic [39:0] addrs [2] = '{40'h4000, 40'h4002};
      logic [2:0]  sizes [2] = '{3'b111, 3'd2};
      for (int v = 0; v < 2; v++) begin
         seen = 1'b0;
         send(L15_STORE_RQ, 2'd1, addrs[v], sizes[v], 64'hDEAD);
         for (int i = 0; i < 8; i++) begin
            seen |= bus.mem_req_valid;
            if (bus.l15_rtrn.l15_val) break;
            step();
         end
         checks++;
         if (seen !== 1'b0) begin errs++; $display("FAIL sterr%0d_mem: mem_req_valid seen=%b want 0", v, seen); end
         checks++;
         if (bus.l15_rtrn.l15_val !== 1'b1 || bus.l15_rtrn.l15_returntype !== L15_ERR_RET || bus.l15_rtrn.l15_error !== 1'b1)
            begin errs++; $display("FAIL sterr%0d_rtrn: val=%b type=%h err=%b want 1/c/1", v, bus.l15_rtrn.l15_val, bus.l15_rtrn.l15_returntype, bus.l15_rtrn.l15_error); end
         ack_rtrn();
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int w; logic [39:0] a; logic we; logic [31:0] be; logic [255:0] wd;
      bus.l15_req.l15_val    = 1'b1;
      bus.l15_req.l15_rqtype = L15_LOAD_RQ;
      bus.l15_req.l15_size   = 3'd3;
      for (int i = 0; i < 4; i++) begin
         bus.l15_req.l15_threadid = 2'(i < 2 ? i : 2);
         bus.l15_req.l15_address  = 40'h5000 + 40'(32 * (i < 2 ? i : 2));
         checks++;
         if (bus.l15_rtrn.l15_ack !== (i < 2)) begin errs++; $display("FAIL b2b_ack%0d: got %b want %b", i, bus.l15_rtrn.l15_ack, i < 2); end
         step();
      end
      bus.l15_req.l15_val = 1'b0;
      do_mem(line, ok, w, a, we, be, wd);
      checks++;
      if (!ok || a !== 40'h5000 || bus.l15_rtrn.l15_threadid !== 2'd0)
         begin errs++; $display("FAIL b2b_first: ok=%b addr=%h tid=%0d want 1/5000/0", ok, a, bus.l15_rtrn.l15_threadid); end
      ack_rtrn();
      do_mem(line_b, ok, w, a, we, be, wd);
      checks++;
      if (!ok || a !== 40'h5020 || bus.l15_rtrn.l15_threadid !== 2'd1)
         begin errs++; $display("FAIL b2b_second: ok=%b addr=%h tid=%0d want 1/5020/1", ok, a, bus.l15_rtrn.l15_threadid); end
      checks++;
      if (bus.l15_rtrn.l15_data_0 !== 64'hFFFEFDFCFBFAF9F8) begin errs++; $display("FAIL b2b_d0: got %h want fffefdfcfbfaf9f8", bus.l15_rtrn.l15_data_0); end
      ack_rtrn();
      checks++;
      if (bus.l15_rtrn.l15_val !== 1'b0 || bus.l15_rtrn.l15_ack !== 1'b1)
         begin errs++; $display("FAIL b2b_drain: val=%b ack=%b want 0/1", bus.l15_rtrn.l15_val, bus.l15_rtrn.l15_ack); end
   endtask

   task automatic test_reset_midflight();
      bit ok;
      send(L15_LOAD_RQ, 2'd1, 40'h6000, 3'd3, 64'h0);
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (bus.mem_req_valid) ok = 1'b1;
         else step();
      end
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      rst_i = 1'b1;
      step();
      checks++;
      if (!ok || bus.l15_rtrn !== '0 || bus.mem_req_valid !== 1'b0)
         begin errs++; $display("FAIL rst_mid: ok=%b rtrn=%h memvalid=%b want all 0", ok, bus.l15_rtrn, bus.mem_req_valid); end
      rst_i = 1'b0;
      step();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = line;
      step();
      bus.mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.l15_rtrn.l15_val !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.l15_rtrn.l15_ack !== 1'b1)
            begin errs++; $display("FAIL rst_late%0d: val=%b memvalid=%b ack=%b want 0/0/1", i, bus.l15_rtrn.l15_val, bus.mem_req_valid, bus.l15_rtrn.l15_ack); end
         step();
      end
   endtask

   task automatic test_inval();
      bit ok;
      bus.inval_valid = 1'b1;
      bus.inval_addr  = 40'hABCD0;
      step();
      bus.inval_valid = 1'b0;
`ifdef HPDC_L15_RESP_INVAL_EN
      wait_rtrn(ok);
      checks++;
      if (!ok || bus.l15_rtrn.l15_returntype !== L15_EVICT_REQ || bus.l15_rtrn.l15_inval_icache_inval !== 1'b1)
         begin errs++; $display("FAIL inval_type: ok=%b type=%h icinv=%b want 1/3/1", ok, bus.l15_rtrn.l15_returntype, bus.l15_rtrn.l15_inval_icache_inval); end
      checks++;
      if (bus.l15_rtrn.l15_inval_address_15_4 !== 12'hBCD) begin errs++; $display("FAIL inval_addr: got %h want bcd", bus.l15_rtrn.l15_inval_address_15_4); end
      ack_rtrn();
      checks++;
      if (bus.l15_rtrn.l15_val !== 1'b0) begin errs++; $display("FAIL inval_pop: val=%b want 0", bus.l15_rtrn.l15_val); end
`else
      for (int i = 0; i < 4; i++) begin
         ok = bus.l15_rtrn.l15_val === 1'b0 && bus.l15_rtrn.l15_inval_icache_inval === 1'b0 && bus.l15_rtrn.l15_inval_address_15_4 === 12'h0;
         checks++;
         if (!ok) begin errs++; $display("FAIL inval_ignored%0d: val=%b icinv=%b addr=%h want 0/0/0", i, bus.l15_rtrn.l15_val, bus.l15_rtrn.l15_inval_icache_inval, bus.l15_rtrn.l15_inval_address_15_4); end
         step();
      end
`endif
   endtask

   initial begin
      bus.l15_req       = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      bus.inval_valid   = 1'b0;
      bus.inval_addr    = '0;
      for (int i = 0; i < 32; i++) line[8*i +: 8] = 8'(i);
      line_b = ~line;
      test_reset();
      test_imiss();
      test_load();
      test_store();
      test_store_err();
      test_back_to_back();
      test_reset_midflight();
      test_inval();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
